bcd_timer_ctrl: RTL and testbench

Sequencing controller for a cascaded chain of BCD decade counters, forming a programmable up/down timer. It holds a preset and runs the digit chain from a divided tick. It handles start/pause/clear commands and flags completion with a one-cycle `done` pulse. It sits between the panel/control logic and the 7-segment display path; the digit chain is instantiated internally.

---
 rtl/timer_pkg.sv | 14 +
 rtl/bcd_timer_ctrl_if.sv | 10 +
 rtl/bcd_digit.sv | 21 ++
 rtl/bcd_timer_ctrl.sv | 80 ++++++++
 tb/tb_bcd_timer_ctrl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding, BCD digit type and decade helpers for the BCD timer
package timer_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2, DONE = 2'd3} state_t;
    typedef logic [3:0] bcd_t;
    localparam bcd_t BCD_MAX = 4'd9;
    localparam bcd_t BCD_MIN = 4'd0;
    // One decade step in the given direction, wrapping at the limit
    function automatic bcd_t bcd_step(input bcd_t q, input logic up);
        return up ? ((q >= BCD_MAX) ? BCD_MIN : q + 4'd1) : ((q == BCD_MIN) ? BCD_MAX : q - 4'd1);
    endfunction
    function automatic bcd_t bcd_clamp(input bcd_t q);
        return (q > BCD_MAX) ? BCD_MAX : q;
    endfunction
endpackage

// File: rtl/bcd_timer_ctrl_if.sv
// bcd_timer_ctrl_if: panel-side command/status bundle of the BCD timer.
// master drives up/load/load_val/start/pause/clear and observes value/state/running/done;
// slave is the timer side.
interface bcd_timer_ctrl_if #(parameter int DIGITS = 4);
    logic up, load, start, pause, clear, running, done;
    logic [4*DIGITS-1:0] load_val, value;
    logic [1:0] state;
    modport master(output up, load, load_val, start, pause, clear, input value, state, running, done);
    modport slave(input up, load, load_val, start, pause, clear, output value, state, running, done);
endinterface

// File: rtl/bcd_digit.sv
// bcd_digit: one decade of the counter chain.
// clk/reset clock and async reset; en steps q in direction up; ld loads d (wins over en);
// q is the registered digit; lim is high when q sits at the wrap point for direction up.
module bcd_digit
    import timer_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic up,
    input  logic ld,
    input  bcd_t d,
    output bcd_t q,
    output logic lim
);
    assign lim = (q == (up ? BCD_MAX : BCD_MIN));
    always_ff @(posedge clk or posedge reset)
        if (reset) q <= BCD_MIN;
        else if (ld) q <= d;
        else if (en) q <= bcd_step(q, up);
endmodule

// File: rtl/bcd_timer_ctrl.sv
// bcd_timer_ctrl: start/pause/clear sequencer for a cascaded BCD up/down timer.
// clk, reset (async, active high); bus.slave carries up, load, load_val, start, pause, clear
// in, and value (BCD), state, running and the one-cycle done pulse out, all registered.
module bcd_timer_ctrl
    import timer_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int TICK_DIV = 4
) (
    input logic clk,
    input logic reset,
    bcd_timer_ctrl_if.slave bus
);
    localparam int W = 4 * DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);
    state_t state, state_nxt;
    logic [PW-1:0] psc;
    logic [W-1:0] preset, preset_c, nxt, d_val, value;
    logic [DIGITS-1:0] lim, carry;
    logic dir, done_q, do_load, do_start, do_pause, idle_like, begin_run, tick, term, ld;
    // Commands are resolved by raw priority: a higher command masks lower ones even if it is ignored
    always_comb begin
        do_load = !bus.clear && bus.load;
        do_start = !bus.clear && !bus.load && bus.start;
        do_pause = !bus.clear && !bus.load && !bus.start && bus.pause;
        idle_like = (state == IDLE) || (state == DONE);
        begin_run = do_start && idle_like;
        tick = (state == RUN) && !bus.clear && !do_pause && (psc == PLAST);
        ld = bus.clear || begin_run;
        d_val = (!bus.clear && !bus.up) ? preset : '0;
        term = tick && (nxt == (dir ? preset : W'(0)));
    end
    // Ripple enable: digit i steps when all lower digits are at their limit.
    // nxt is the value the chain will hold after this edge, used for the same-edge terminal compare.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        if (i == 0) begin : g_lsd
            assign carry[i] = tick;
        end else begin : g_upper
            assign carry[i] = carry[i-1] && lim[i-1];
        end
        bcd_digit u_digit (
            .clk(clk), .reset(reset), .en(carry[i]), .up(dir), .ld(ld),
            .d(d_val[4*i +: 4]), .q(value[4*i +: 4]), .lim(lim[i])
        );
        assign nxt[4*i +: 4] = !carry[i] ? value[4*i +: 4] :
                               lim[i] ? (dir ? BCD_MIN : BCD_MAX) :
                               dir ? value[4*i +: 4] + 4'd1 : value[4*i +: 4] - 4'd1;
        assign preset_c[4*i +: 4] = bcd_clamp(bus.load_val[4*i +: 4]);
    end
    always_comb begin
        state_nxt = state;
        if (bus.clear) state_nxt = IDLE;
        else if (begin_run) state_nxt = (preset == '0) ? DONE : RUN;
        else if (do_start && state == PAUSED) state_nxt = RUN;
        else if (do_pause && state == RUN) state_nxt = PAUSED;
        else if (term) state_nxt = DONE;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_nxt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psc <= '0;
            preset <= '0;
            dir <= 1'b1;
            done_q <= 1'b0;
        end else begin
            done_q <= (begin_run && preset == '0) || term;
            if (do_load && idle_like) preset <= preset_c;
            if (begin_run) dir <= bus.up;
            if (ld) psc <= '0;
            else if (state == RUN && !do_pause) psc <= tick ? '0 : psc + 1'b1;
        end
    end
    assign bus.value = value;
    assign bus.state = state;
    assign bus.running = (state == RUN);
    assign bus.done = done_q;
endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// tb_bcd_timer_ctrl: scoreboard bench; an integer-level timer model queues expected output changes,
// a negedge monitor pops and compares them whenever the DUT outputs change
module tb_bcd_timer_ctrl;
    localparam int DIGITS = 4;
    localparam int TICK_DIV = 4;
    typedef struct {
        logic [15:0] value;
        logic [1:0] state;
        logic done;
        logic running;
        int cyc;
    } obs_t;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    obs_t exp_q[$];
    obs_t last_seen, m_last;
    bit primed = 0;
    bit mon_en = 0;
    int m_state, m_val, m_preset, m_phase;
    bit m_dir, m_done;
    bcd_timer_ctrl_if #(.DIGITS(DIGITS)) bus();
    bcd_timer_ctrl #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic int dec_of(input logic [15:0] b);
        int v = 0;
        for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + ((b[4*i +: 4] > 4'd9) ? 9 : int'(b[4*i +: 4]));
        return v;
    endfunction
    function automatic logic [15:0] bcd_of(input int v);
        logic [15:0] r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction
    function automatic bit same(input obs_t a, input obs_t b);
        return a.value === b.value && a.state === b.state && a.done === b.done && a.running === b.running;
    endfunction
    task automatic push_obs();
        obs_t o;
        o = '{bcd_of(m_val), 2'(m_state), m_done, m_state == 1, cyc + 1};
        if (!same(o, m_last)) exp_q.push_back(o);
        m_last = o;
    endtask
    task automatic model_reset();
        m_state = 0; m_val = 0; m_preset = 0; m_phase = 0; m_dir = 1; m_done = 0;
    endtask
    // Timer behaviour in plain integers: decimal count, preset and elapsed clocks since the last step
    task automatic model_step(input bit cl, ld, st, pa, up, input logic [15:0] lv);
        bit idle_like;
        bit step;
        idle_like = (m_state == 0 || m_state == 3);
        step = 0;
        m_done = 0;
        if (cl) begin
            m_state = 0; m_val = 0; m_phase = 0;
        end else if (ld) begin
            if (idle_like) m_preset = dec_of(lv);
            else step = (m_state == 1);
        end else if (st) begin
            if (idle_like) begin
                m_dir = up;
                m_val = up ? 0 : m_preset;
                m_phase = 0;
                if (m_preset == 0) begin m_state = 3; m_done = 1; end
                else m_state = 1;
            end else if (m_state == 2) m_state = 1;
            else step = 1;
        end else if (pa && m_state == 1) m_state = 2;
        else step = (m_state == 1);
        if (step) begin
            m_phase++;
            if (m_phase == TICK_DIV) begin
                m_phase = 0;
                m_val = m_dir ? m_val + 1 : m_val - 1;
                if (m_val == (m_dir ? m_preset : 0)) begin m_state = 3; m_done = 1; end
            end
        end
        push_obs();
    endtask
    task automatic do_cycle(input bit cl, ld, st, pa, up, input logic [15:0] lv);
        @(negedge clk);
        #1;
        bus.clear = cl; bus.load = ld; bus.start = st; bus.pause = pa; bus.up = up; bus.load_val = lv;
        model_step(cl, ld, st, pa, up, lv);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 0, bus.up, 16'h0);
    endtask
    task automatic check_reset_outputs(input string name);
        checks++;
        if (bus.value !== 16'h0 || bus.state !== 2'd0 || bus.done !== 1'b0 || bus.running !== 1'b0) begin
            errors++;
            $display("FAIL %s: got value=%h state=%0d done=%b running=%b, expected value=0000 state=0 done=0 running=0",
                     name, bus.value, bus.state, bus.done, bus.running);
        end
    endtask
    task automatic pulse_reset();
        @(negedge clk);
        #1;
        bus.clear = 0; bus.load = 0; bus.start = 0; bus.pause = 0; bus.load_val = 16'h0;
        reset = 1'b1;
        #1;
        check_reset_outputs("reset_mid_run");
        #1;
        reset = 1'b0;
        model_reset();
        push_obs();
    endtask
    always @(negedge clk) if (mon_en) begin
        obs_t now, e;
        now = '{bus.value, bus.state, bus.done, bus.running, cyc};
        if (!primed) primed = 1;
        else if (!same(now, last_seen)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change: got value=%h state=%0d done=%b running=%b at cycle %0d, expected no change",
                         now.value, now.state, now.done, now.running, now.cyc);
            end else begin
                e = exp_q.pop_front();
                if (!same(now, e) || now.cyc != e.cyc) begin
                    errors++;
                    $display("FAIL output_change: got value=%h state=%0d done=%b running=%b cycle=%0d, expected value=%h state=%0d done=%b running=%b cycle=%0d",
                             now.value, now.state, now.done, now.running, now.cyc, e.value, e.state, e.done, e.running, e.cyc);
                end
            end
        end
        last_seen = now;
    end
    initial begin
        bus.clear = 0; bus.load = 0; bus.start = 0; bus.pause = 0; bus.up = 1; bus.load_val = 16'h0;
        #1 reset = 1'b1;
        #1 check_reset_outputs("reset_initial");
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b0;
        model_reset();
        m_last = '{16'h0, 2'd0, 1'b0, 1'b0, 0};
        mon_en = 1;
        idle(2);
        // reset while running at 0042
        do_cycle(0, 1, 0, 0, 1, 16'h0050);
        do_cycle(0, 0, 1, 0, 1, 16'h0);
        idle(42 * TICK_DIV);
        pulse_reset();
        idle(3);
        // down count across a digit boundary
        do_cycle(0, 1, 0, 0, 0, 16'h0012);
        do_cycle(0, 0, 1, 0, 0, 16'h0);
        idle(12 * TICK_DIV + 4);
        // up count through a two-digit carry
        do_cycle(0, 1, 0, 0, 1, 16'h0105);
        do_cycle(0, 0, 1, 0, 1, 16'h0);
        idle(105 * TICK_DIV + 4);
        // clamped preset, down start
        do_cycle(0, 1, 0, 0, 0, 16'h00F3);
        do_cycle(0, 0, 1, 0, 0, 16'h0);
        idle(6);
        do_cycle(1, 0, 0, 0, 0, 16'h0);
        idle(2);
        // pause after three steps, resume, then clear together with start
        do_cycle(0, 1, 0, 0, 1, 16'h0030);
        do_cycle(0, 0, 1, 0, 1, 16'h0);
        idle(3 * TICK_DIV + 1);
        do_cycle(0, 0, 0, 1, 1, 16'h0);
        idle(20);
        do_cycle(0, 0, 1, 0, 1, 16'h0);
        idle(10);
        do_cycle(1, 0, 1, 0, 1, 16'h0);
        idle(3);
        // zero preset finishes at once; load during RUN is ignored
        do_cycle(0, 1, 0, 0, 1, 16'h0000);
        do_cycle(0, 0, 1, 0, 1, 16'h0);
        idle(3);
        do_cycle(0, 1, 0, 0, 1, 16'h0002);
        do_cycle(0, 0, 1, 0, 1, 16'h0);
        idle(2);
        do_cycle(0, 1, 0, 0, 1, 16'h0009);
        idle(2 * TICK_DIV + 3);
        // randomized command mix
        for (int n = 0; n < 3000; n++) begin
            bit cl, ld, st, pa, up;
            logic [15:0] lv;
            cl = ($urandom_range(0, 99) < 2);
            ld = ($urandom_range(0, 15) == 0);
            st = ($urandom_range(0, 15) == 0);
            pa = ($urandom_range(0, 31) == 0);
            up = 1'($urandom_range(0, 1));
            lv = ($urandom_range(0, 3) == 0) ? 16'($urandom) : {8'h00, 8'($urandom)};
            do_cycle(cl, ld, st, pa, up, lv);
        end
        idle(3);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected: got %0d pending changes, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
